// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop
// shift register that drives TX, one bit every BAUD_DIV clocks.
module uart_tx #(
    parameter int BAUD_DIV   = 21,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       TX,
    output logic       dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] CNT_FULL  = (PW+1)'(FIFO_DEPTH);
    localparam logic [6:0]  BAUD_LAST = 7'(BAUD_DIV - 1);

    localparam logic IDLE = 1'b0;
    localparam logic XMIT = 1'b1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          empty;
    logic          push;
    logic          pop;

    logic          state;
    logic [9:0]    shift_reg;
    logic [3:0]    bit_cnt;
    logic [6:0]    baud_cnt;
    logic          baud_tick;

    // Handshake: trmt is a one-cycle push request, accepted whenever full is low;
    // there is no back-pressure wait, so a push while full is simply dropped.
    assign empty     = (count == '0);
    assign push      = trmt && !full;
    assign pop       = (state == IDLE) && !empty;
    assign baud_tick = (baud_cnt == BAUD_LAST);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
        end
    end

    // The shift register idles at all 1s, so TX stays high between frames
    // and after the stop bit has been shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '1;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                if (!empty) begin
                    shift_reg <= {1'b1, mem[rd_ptr], 1'b0};
                    bit_cnt   <= '0;
                    baud_cnt  <= '0;
                    state     <= XMIT;
                end
            end else begin
                if (baud_tick) begin
                    shift_reg <= {1'b1, shift_reg[9:1]};
                    baud_cnt  <= '0;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == 4'd9) begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

    assign TX        = shift_reg[0];
    assign busy      = (state == XMIT) || !empty;
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-based frame-timing model predicts the line every
// cycle, and a behavioural receiver decodes TX into bytes for the scoreboard.
module tb_uart_tx;

    localparam int BD    = 21;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BD;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       trmt    = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       full;
    logic       busy;
    logic       tx_done;
    logic       TX;
    logic       dbg_state;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .full     (full),
        .busy     (busy),
        .tx_done  (tx_done),
        .TX       (TX),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Queue of waiting bytes plus "cycles since the frame was loaded".
    // exp_vec = {TX, tx_done, busy, full} expected after each edge.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_cur    = 8'h00;
    logic [3:0] exp_vec  = 4'b1000;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int   n_before;
        logic done;
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            exp_vec  = 4'b1000;
        end else begin
            n_before = m_q.size();
            done     = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) begin
                    m_active = 1'b0;
                    done     = 1'b1;
                end
            end else if (n_before > 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (trmt && n_before < DEPTH) begin
                m_q.push_back(tx_data);
                exp_q.push_back(tx_data);
            end
            exp_vec = {(m_active ? frame_bit(m_cur, m_t / BD) : 1'b1), done,
                       (m_active || m_q.size() > 0), (m_q.size() == DEPTH)};
        end
    end

    // ---------------- behavioural receiver (loopback) ----------------
    logic [7:0] rx_q[$];
    int         rdy_cnt = 0;
    int         rx_bad  = 0;
    bit         rx_act  = 1'b0;
    int         rx_t    = 0;
    logic [9:0] rx_sh   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_act = 1'b0;
            rx_t   = 0;
        end else if (!rx_act) begin
            if (TX === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % BD == BD / 2) begin
                rx_sh[rx_t / BD] = TX;
                if (rx_t / BD == 9) begin
                    rx_act = 1'b0;
                    rdy_cnt++;
                    if (rx_sh[0] === 1'b0 && rx_sh[9] === 1'b1) rx_q.push_back(rx_sh[8:1]);
                    else rx_bad++;
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        trmt  = 1'b0;
        #1;
        checks++;
        if ({TX, tx_done, busy, full} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=1000", {TX, tx_done, busy, full});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== exp_vec) begin
                failures++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", c, {TX, tx_done, busy, full}, exp_vec);
            end
        end
    endtask

    task automatic test_single();
        int fall_i = -1;
        int done_i = -1;
        int ndone  = 0;
        rx_q.delete();
        exp_q.delete();
        for (int c = 0; c < FRAME + 20; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== exp_vec) begin
                failures++;
                $display("FAIL single_line c=%0d got=%b exp=%b", c, {TX, tx_done, busy, full}, exp_vec);
            end
            if (TX === 1'b0 && fall_i < 0) fall_i = c;
            if (tx_done === 1'b1) begin
                ndone++;
                if (done_i < 0) done_i = c;
            end
            trmt    = (c == 0);
            tx_data = 8'hA5;
        end
        trmt = 1'b0;
        // push driven at c=0, captured at the next edge; start bit loads one edge later
        checks++;
        if (fall_i !== 2) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=2", fall_i);
        end
        checks++;
        if (done_i - fall_i !== FRAME) begin
            failures++;
            $display("FAIL single_done_time got=%0d exp=%0d", done_i - fall_i, FRAME);
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL single_done_count got=%0d exp=1", ndone);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_after got=%b exp=0", busy);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_byte got_n=%0d exp=a5", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};
        int   ndone    = 0;
        logic saw_full = 1'b0;
        rx_q.delete();
        exp_q.delete();
        for (int c = 0; c < 4 * (FRAME + 1) + 20; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== exp_vec) begin
                failures++;
                $display("FAIL b2b_line c=%0d got=%b exp=%b", c, {TX, tx_done, busy, full}, exp_vec);
            end
            if (tx_done === 1'b1) ndone++;
            if (full !== 1'b0) saw_full = 1'b1;
            trmt = (c < 4);
            if (c < 4) tx_data = vals[c];
        end
        trmt = 1'b0;
        checks++;
        if (ndone !== 4) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=4", ndone);
        end
        checks++;
        if (saw_full !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full got=%b exp=0", saw_full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== vals[i]) begin
                failures++;
                $display("FAIL b2b_byte i=%0d got_n=%0d exp=%h", i, rx_q.size(), vals[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int ndone     = 0;
        int full_on_i = -1;
        int full_off  = -1;
        rx_q.delete();
        exp_q.delete();
        for (int c = 0; c < 5 * (FRAME + 1) + 20; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== exp_vec) begin
                failures++;
                $display("FAIL ovf_line c=%0d got=%b exp=%b", c, {TX, tx_done, busy, full}, exp_vec);
            end
            if (tx_done === 1'b1) ndone++;
            if (full === 1'b1 && full_on_i < 0) full_on_i = c;
            if (full_on_i >= 0 && full_off < 0 && full === 1'b0) full_off = c;
            trmt    = (c < 6);
            tx_data = 8'(8'h11 * (c + 1));
        end
        trmt = 1'b0;
        // full is visible in the cycle the sixth push is presented
        checks++;
        if (full_on_i !== 5) begin
            failures++;
            $display("FAIL ovf_full_on got=%0d exp=5", full_on_i);
        end
        // first frame loads at the 2nd edge; its successor pops FRAME+1 edges later
        checks++;
        if (full_off !== FRAME + 3) begin
            failures++;
            $display("FAIL ovf_full_off got=%0d exp=%0d", full_off, FRAME + 3);
        end
        checks++;
        if (ndone !== 5 || rx_q.size() != 5) begin
            failures++;
            $display("FAIL ovf_count got_done=%0d got_rx=%0d exp=5", ndone, rx_q.size());
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(8'h11 * (i + 1))) begin
                failures++;
                $display("FAIL ovf_byte i=%0d got=%h exp=%h", i, rx_q[i], 8'(8'h11 * (i + 1)));
            end
        end
    endtask

    task automatic test_coincidence();
        int         ndone    = 0;
        logic       saw_full = 1'b0;
        logic [7:0] got;
        logic [7:0] want;
        rx_q.delete();
        exp_q.delete();
        for (int c = 0; c < 5 * (FRAME + 1) + 20; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== exp_vec) begin
                failures++;
                $display("FAIL coin_line c=%0d got=%b exp=%b", c, {TX, tx_done, busy, full}, exp_vec);
            end
            if (c == FRAME + 2) begin
                checks++;
                if (tx_done !== 1'b1) begin
                    failures++;
                    $display("FAIL coin_pop_cycle got=%b exp=1", tx_done);
                end
            end
            if (tx_done === 1'b1) ndone++;
            if (full !== 1'b0) saw_full = 1'b1;
            trmt    = (c < 4) || (c == FRAME + 2);
            tx_data = 8'($urandom);
        end
        trmt = 1'b0;
        checks++;
        if (saw_full !== 1'b0 || ndone !== 5) begin
            failures++;
            $display("FAIL coin_summary got_full=%b got_done=%0d exp=0/5", saw_full, ndone);
        end
        checks++;
        if (rx_q.size() != exp_q.size() || rx_q.size() != 5) begin
            failures++;
            $display("FAIL coin_rx_count got=%0d exp=5", rx_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL coin_byte got=%h exp=%h", got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ndone  = 0;
        int rdy0   = rdy_cnt;
        rx_q.delete();
        exp_q.delete();
        // observation at c shows frame time c-2; stop mid data bit 3 (frame slot 4)
        for (int c = 0; c <= 2 + 4 * BD + BD / 2; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== exp_vec) begin
                failures++;
                $display("FAIL rmid_line c=%0d got=%b exp=%b", c, {TX, tx_done, busy, full}, exp_vec);
            end
            trmt    = (c < 3);
            tx_data = (c == 0) ? 8'hC3 : 8'($urandom);
        end
        trmt  = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({TX, tx_done, busy, full} !== 4'b1000) begin
            failures++;
            $display("FAIL rmid_async got=%b exp=1000", {TX, tx_done, busy, full});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if ({TX, tx_done, busy, full} !== 4'b1000) begin
                failures++;
                $display("FAIL rmid_quiet c=%0d got=%b exp=1000", c, {TX, tx_done, busy, full});
            end
            if (tx_done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0 || rx_q.size() != 0 || rdy_cnt !== rdy0) begin
            failures++;
            $display("FAIL rmid_no_frames got_done=%0d got_rx=%0d exp=0", ndone, rx_q.size());
        end
    endtask

    task automatic test_loopback();
        int         sent  = 0;
        int         ndone = 0;
        int         c     = 0;
        int         rdy0  = rdy_cnt;
        int         limit = 256 * (FRAME + 1) + 2000;
        logic [7:0] got;
        logic [7:0] want;
        rx_q.delete();
        exp_q.delete();
        while ((sent < 256 || exp_vec[1]) && c < limit) begin
            @(negedge clk);
            c++;
            if (tx_done === 1'b1) ndone++;
            if (sent < 256 && exp_vec[0] == 1'b0 && $urandom_range(0, 3) != 0) begin
                trmt    = 1'b1;
                tx_data = 8'($urandom);
                sent++;
            end else begin
                trmt = 1'b0;
            end
        end
        trmt = 1'b0;
        checks++;
        if (c >= limit) begin
            failures++;
            $display("FAIL loop_timeout got=%0d exp<%0d", c, limit);
        end
        checks++;
        if (rx_q.size() != 256 || rdy_cnt - rdy0 !== 256 || ndone !== 256) begin
            failures++;
            $display("FAIL loop_count got_rx=%0d got_rdy=%0d got_done=%0d exp=256",
                     rx_q.size(), rdy_cnt - rdy0, ndone);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL loop_byte got=%h exp=%h", got, want);
            end
        end
        checks++;
        if (rx_bad !== 0) begin
            failures++;
            $display("FAIL framing got=%0d exp=0", rx_bad);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_coincidence();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter that serializes bytes onto the TX line as 8N1 frames: one start bit (0), eight data bits LSB first, one stop bit (1). Bytes are queued in a small internal FIFO, so a producer can issue several bytes back-to-back without waiting for each frame to finish. The block is the transmit counterpart to UART_rx. It sits on the same clock domain and drives the serial line that a UART_rx instance samples.

## Interface
- BAUD_DIV, default 21: clocks per bit period. Legal range is 2 to 128. Baud counter is 7 bits wide.
- FIFO_DEPTH, default 4: byte entries in the queue. Must be a power of 2 and at least 2.

- clk, input, 1: system clock. All logic is on posedge.
- rst_n, input, 1: reset, asynchronous, active-low.
- trmt, input, 1: push request. Writes tx_data into the FIFO on the clock edge where trmt=1 and full=0.
- tx_data, input, 8: byte to queue. Sampled only on an accepted push.
- full, output, 1: FIFO holds FIFO_DEPTH entries. Registered.
- busy, output, 1: frame in progress, or FIFO not empty.
- tx_done, output, 1: high for exactly one cycle after each frame's stop bit completes.
- TX, output, 1: serial line, idles high. Driven directly from a flop.

## Operation
- One clock; reset is asynchronous and active-low.
- **Reset values:**
  - TX=1; the 10-bit shift register resets to all 1s.
  - full=0, busy=0, tx_done=0.
  - FIFO count, read pointer and write pointer are 0.
  - bit_cnt=0, baud_cnt=0, state=IDLE.
- **FIFO:**
  - Circular buffer with read pointer, write pointer and count. The pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Push happens when trmt && !full. When full=1, trmt is ignored and the byte is dropped, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged. Both pointers advance.
  - full = (count == FIFO_DEPTH). empty = (count == 0).
- **State machine, states IDLE and XMIT:**
  - IDLE, FIFO not empty: pop the head entry. Load the shift register with {1'b1, data, 1'b0}. Clear bit_cnt and baud_cnt. Go to XMIT.
  - IDLE, FIFO empty: stay in IDLE. TX=1.
  - XMIT: baud_cnt increments every clock. When baud_cnt == BAUD_DIV-1:
    - shift right, shifting a 1 in;
    - clear baud_cnt;
    - increment bit_cnt.
  - XMIT, shift with bit_cnt == 9 (stop bit finished): go to IDLE and pulse tx_done. TX stays high because 1s were shifted in.
- TX = shift_reg[0] at all times.
- busy = (state == XMIT) || !empty.

## Timing
- **Push to start bit:** a push captured at edge E0 is seen by IDLE in the following cycle. The load occurs at E1 and TX falls after E1. Latency is 1 clock when the block is idle.
- **Bit period:** each bit is held for exactly BAUD_DIV clocks. A frame lasts 10*BAUD_DIV clocks, measured from TX falling to the end of the stop bit.
- **Inter-frame gap:** exactly 1 clock of TX=1 beyond the stop bit (the IDLE cycle). tx_done is high during that cycle.
- The pop and the tx_done=0 transition happen on the same edge that starts the next frame.
- **Reset mid-frame:** TX goes to 1 asynchronously. The partial frame is aborted and all queued bytes are discarded. tx_done does not pulse.
- No glitches on TX. It changes only on clock edges, or asynchronously to 1 on reset.

## Test plan
- **Single byte 0xA5, BAUD_DIV=21, idle start:**
  - pulse trmt for 1 cycle;
  - TX falls 1 clock later;
  - per 21-clock slot TX reads 0 | 1,0,1,0,0,1,0,1 | 1;
  - tx_done is high for exactly 1 cycle, 210 clocks after TX fell;
  - busy is low afterward.
- **Back-to-back bytes 0x00, 0xFF, 0x3C, 0x81 pushed on 4 consecutive cycles:**
  - four frames are sent in order;
  - each gap is exactly 1 high clock;
  - tx_done pulses 4 times;
  - full never asserts.
- **Overflow: six consecutive pushes 0x11–0x66 from idle:**
  - full asserts on the sixth cycle, so 0x66 is dropped;
  - frames 0x11–0x55 are sent in order;
  - full deasserts on the first pop after that.
- **Push/pop coincidence:** with count=FIFO_DEPTH-1 while a frame ends, assert trmt in the pop cycle. The byte is accepted and the count stays unchanged.
- **Reset mid-frame:**
  - assert rst_n=0 during data bit 3 of 0xC3 with two bytes queued;
  - TX=1 immediately;
  - full=0, busy=0 after reset;
  - no further frames and no tx_done until new pushes.
- **Loopback into UART_rx (matching bit period):** for 256 random bytes, rx_data equals the sent byte and rdy rises once per frame.
